// File: rtl/tt_um_sky_serial_sub.sv
// Bit-serial 8-bit subtractor (A - B mod 256) behind the TinyTapeout pin-out.
// One difference bit per clock through a single full-subtractor with a registered borrow.
module tt_um_sky_serial_sub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, res_reg;
  logic               br, done_f;
  logic [CNT_W-1:0]   cnt;

  logic start, load_a, load_b;
  logic a0, b0, d, br_next, last_bit, accept;

  assign start  = uio_in[0];
  assign load_a = uio_in[1];
  assign load_b = uio_in[2];

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:3]};

  assign a0       = a_reg[0];
  assign b0       = b_reg[0];
  assign d        = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = (state == IDLE) || (state == DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN:        if (last_bit) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Start outranks the loads: a cycle with start set never touches the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      done_f  <= 1'b0;
    end else if (state == RUN) begin
      br      <= br_next;
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      res_reg <= {d, res_reg[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
      if (last_bit) done_f <= 1'b1;
    end else if (accept) begin
      if (start) begin
        br      <= 1'b0;
        cnt     <= '0;
        res_reg <= '0;
        done_f  <= 1'b0;
      end else begin
        if (load_a) a_reg <= ui_in;
        if (load_b) b_reg <= ui_in;
      end
    end
  end

  assign uo_out  = res_reg;
  assign uio_out = {done_f & (res_reg == '0), br, done_f, state == RUN, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_sky_serial_sub.sv
// Directed bench for tt_um_sky_serial_sub with hand-computed results.
module tb_tt_um_sky_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;

  tt_um_sky_serial_sub dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one control/data pair for a single sampling edge, return #1 after it.
  task automatic apply(input logic [7:0] ctrl, input logic [7:0] data);
    @(negedge clk);
    uio_in = ctrl;
    ui_in  = data;
    @(posedge clk);
    #1;
    uio_in = '0;
    ui_in  = '0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    apply(8'h02, a);
    apply(8'h04, b);
  endtask

  // Start edge E0, then E1..E8 process bits; result expected right after E8.
  task automatic run(input string tag, input logic [7:0] start_ctrl, input logic [7:0] start_data,
                     input bit noisy, input logic [7:0] exp_res, input logic [7:0] exp_status);
    apply(start_ctrl, start_data);
    check({tag, "_e0_status"}, uio_out, 8'h10);
    for (int i = 0; i < 7; i++) begin
      if (noisy) apply(8'h07, 8'hFF);
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_e7_busy_done"}, {6'b0, uio_out[5:4]}, 8'h01);
    @(posedge clk);
    #1;
    check({tag, "_result"}, uo_out, exp_res);
    check({tag, "_status"}, uio_out, exp_status);
  endtask

  initial begin
    // Reset with garbage on inputs
    ui_in  = 8'hA5;
    uio_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);
    @(negedge clk);
    uio_in = '0;
    ui_in  = '0;
    rst_n  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_uo", uo_out, 8'h00);
    check("post_rst_uio", uio_out, 8'h00);

    load(8'h5A, 8'h23);
    run("basic", 8'h01, 8'h00, 1'b0, 8'h37, 8'h20);

    load(8'h10, 8'h20);
    run("under1", 8'h01, 8'h00, 1'b0, 8'hF0, 8'h60);

    load(8'h00, 8'h01);
    run("under2", 8'h01, 8'h00, 1'b0, 8'hFF, 8'h60);

    apply(8'h06, 8'h7F);
    run("zero", 8'h01, 8'h00, 1'b0, 8'h00, 8'hA0);

    load(8'h5A, 8'h23);
    run("noisy", 8'h01, 8'h00, 1'b1, 8'h37, 8'h20);

    // Operands are shifted out; start+load_a must not load A, so 0 - 0 = 0
    run("start_ld", 8'h03, 8'hFF, 1'b0, 8'h00, 8'hA0);

    // Abort mid-run
    load(8'hC8, 8'h64);
    apply(8'h01, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", {7'b0, uio_out[4]}, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo", uo_out, 8'h00);
    check("mid_rst_uio", uio_out, 8'h00);
    check("mid_rst_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;

    load(8'hC8, 8'h64);
    run("after_rst", 8'h01, 8'h00, 1'b0, 8'h64, 8'h20);
    check("final_oe", uio_oe, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
